// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the iterative shift/rotate sequencer.
// Also holds small decode helpers used by the datapath stage.
package shift_sequencer_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  // op[1] selects direction, op[0] clear means the displaced bits wrap around
  function automatic logic op_is_right(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_rotate(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between the execute stage and the shift sequencer.
interface shift_sequencer_if #(
    parameter int unsigned Width = 16,
    parameter int unsigned CntW  = 4
) ();

    logic             Start;
    logic [1:0]       Op;
    logic [Width-1:0] In;
    logic [CntW-1:0]  Cnt;
    logic             Busy;
    logic             Done;
    logic [Width-1:0] Out;

    modport master (
        output Start, Op, In, Cnt,
        input  Busy, Done, Out
    );

    modport slave (
        input  Start, Op, In, Cnt,
        output Busy, Done, Out
    );

endinterface

// File: rtl/dff.sv
// Register cell with synchronous active-high reset to zero.
module dff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/mux2_1.sv
// Single-bit 2:1 multiplexer cell.
module mux2_1 (
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/shift_sequencer_stage.sv
// One power-of-two shift/rotate stage; amount is 2^stage_i, bypassed when en_i is low.
module shift_stage
  import shift_sequencer_pkg::*;
#(
    parameter int unsigned Width  = 16,
    parameter int unsigned StageW = 2
) (
    input  logic [Width-1:0]  data_i,
    input  logic [1:0]        op_i,
    input  logic [StageW-1:0] stage_i,
    input  logic              en_i,
    output logic [Width-1:0]  result_o
);

    int unsigned      amt;
    logic [Width-1:0] left_shift;
    logic [Width-1:0] right_shift;
    logic [Width-1:0] left_wrap;
    logic [Width-1:0] right_wrap;
    logic [Width-1:0] base;
    logic [Width-1:0] wrap;
    logic [Width-1:0] fill;
    logic             dir_right;
    logic             rotate;

    assign dir_right = op_is_right(op_i);
    assign rotate    = op_is_rotate(op_i);

    // amt never exceeds Width/2, so the wrap shifts stay inside the word
    always_comb begin
        amt         = 32'd1 << stage_i;
        left_shift  = data_i << amt;
        right_shift = data_i >> amt;
        left_wrap   = data_i >> (Width - amt);
        right_wrap  = data_i << (Width - amt);
    end

    for (genvar i = 0; i < Width; i++) begin : g_bit
        mux2_1 u_base_mux (
            .a_i  (left_shift[i]),
            .b_i  (right_shift[i]),
            .sel_i(dir_right),
            .y_o  (base[i])
        );

        mux2_1 u_wrap_mux (
            .a_i  (left_wrap[i]),
            .b_i  (right_wrap[i]),
            .sel_i(dir_right),
            .y_o  (wrap[i])
        );

        mux2_1 u_fill_mux (
            .a_i  (1'b0),
            .b_i  (wrap[i]),
            .sel_i(rotate),
            .y_o  (fill[i])
        );

        mux2_1 u_en_mux (
            .a_i  (data_i[i]),
            .b_i  (base[i] | fill[i]),
            .sel_i(en_i),
            .y_o  (result_o[i])
        );
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative barrel shifter: applies shifts of 8, 4, 2, 1 over four cycles, then pulses Done.
// Out is only written on the final stage, so an aborted operation never reaches it.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
    parameter int unsigned Width = 16,
    parameter int unsigned CntW  = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   bus_io
);

    localparam int unsigned StageW = (CntW > 1) ? $clog2(CntW) : 1;

    logic [1:0]        state_raw_q;
    state_e            state_q;
    state_e            state_d;
    logic [Width-1:0]  data_q;
    logic [Width-1:0]  data_d;
    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_d;
    logic [1:0]        op_q;
    logic [1:0]        op_d;
    logic [StageW-1:0] stage_q;
    logic [StageW-1:0] stage_d;
    logic [Width-1:0]  out_q;
    logic [Width-1:0]  out_d;
    logic [Width-1:0]  stage_res;
    logic              busy;
    logic              done;

    assign state_q = state_e'(state_raw_q);

    dff #(.Width(2)) u_state_reg (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (state_d),
        .q_o  (state_raw_q)
    );

    dff #(.Width(Width)) u_data_reg (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (data_d),
        .q_o  (data_q)
    );

    dff #(.Width(CntW)) u_cnt_reg (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (cnt_d),
        .q_o  (cnt_q)
    );

    dff #(.Width(2)) u_op_reg (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (op_d),
        .q_o  (op_q)
    );

    dff #(.Width(StageW)) u_stage_reg (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (stage_d),
        .q_o  (stage_q)
    );

    dff #(.Width(Width)) u_out_reg (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (out_d),
        .q_o  (out_q)
    );

    shift_stage #(
        .Width (Width),
        .StageW(StageW)
    ) u_stage (
        .data_i  (data_q),
        .op_i    (op_q),
        .stage_i (stage_q),
        .en_i    (cnt_q[stage_q]),
        .result_o(stage_res)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        stage_d = stage_q;
        out_d   = out_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.Start) begin
                    state_d = StShift;
                    data_d  = bus_io.In;
                    cnt_d   = bus_io.Cnt;
                    op_d    = bus_io.Op;
                    stage_d = StageW'(CntW - 1);
                end
            end
            StShift: begin
                busy    = 1'b1;
                data_d  = stage_res;
                stage_d = stage_q - 1'b1;
                if (stage_q == '0) begin
                    out_d   = stage_res;
                    state_d = StDone;
                end
            end
            StDone: begin
                done = 1'b1;
                // Back-to-back request: no idle bubble between operations
                if (bus_io.Start) begin
                    state_d = StShift;
                    data_d  = bus_io.In;
                    cnt_d   = bus_io.Cnt;
                    op_d    = bus_io.Op;
                    stage_d = StageW'(CntW - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus_io.Busy = busy;
    assign bus_io.Done = done;
    assign bus_io.Out  = out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed-vector bench for shift_sequencer: latency, results, back-to-back, ignore and abort.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [15:0] last_out;
    logic        saw_done;

    shift_sequencer_if bus_if ();

    shift_sequencer u_dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns in the first cycle after that edge
    task automatic issue(input logic [1:0] op, input logic [15:0] din, input logic [3:0] cnt);
        bus_if.Start = 1'b1;
        bus_if.Op    = op;
        bus_if.In    = din;
        bus_if.Cnt   = cnt;
        step();
        bus_if.Start = 1'b0;
        bus_if.Op    = 2'($urandom);
        bus_if.In    = 16'($urandom);
        bus_if.Cnt   = 4'($urandom);
    endtask

    // Checks the four busy cycles and the Done cycle; returns in the Done cycle
    task automatic wait_result(input string tag, input logic [15:0] exp);
        for (int c = 1; c <= 4; c++) begin
            check_eq({tag, ":busy"}, 32'(bus_if.Busy), 32'd1);
            check_eq({tag, ":nodone"}, 32'(bus_if.Done), 32'd0);
            check_eq({tag, ":hold"}, 32'(bus_if.Out), 32'(last_out));
            step();
        end
        check_eq({tag, ":done"}, 32'(bus_if.Done), 32'd1);
        check_eq({tag, ":idlebusy"}, 32'(bus_if.Busy), 32'd0);
        check_eq({tag, ":out"}, 32'(bus_if.Out), 32'(exp));
        last_out = exp;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] din,
                          input logic [3:0] cnt, input logic [15:0] exp);
        issue(op, din, cnt);
        wait_result(tag, exp);
        step();
        check_eq({tag, ":pulse"}, 32'(bus_if.Done), 32'd0);
        check_eq({tag, ":keep"}, 32'(bus_if.Out), 32'(exp));
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        last_out     = 16'h0000;
        rst          = 1'b1;
        bus_if.Start = 1'b0;
        bus_if.Op    = OP_ROL;
        bus_if.In    = 16'h0000;
        bus_if.Cnt   = 4'd0;
        step();
        step();
        check_eq("rst:busy", 32'(bus_if.Busy), 32'd0);
        check_eq("rst:done", 32'(bus_if.Done), 32'd0);
        check_eq("rst:out", 32'(bus_if.Out), 32'd0);
        rst = 1'b0;
        step();

        run_op("srl8", OP_SRL, 16'hF00F, 4'd8, 16'h00F0);
        run_op("sll15", OP_SLL, 16'h0001, 4'd15, 16'h8000);
        run_op("rol1", OP_ROL, 16'h8001, 4'd1, 16'h0003);
        run_op("ror1", OP_ROR, 16'h0001, 4'd1, 16'h8000);
        run_op("rol12", OP_ROL, 16'h1234, 4'd12, 16'h4123);
        run_op("sll3", OP_SLL, 16'hFFFF, 4'd3, 16'hFFF8);

        // ROR, then a new SRL accepted in the Done cycle
        issue(OP_ROR, 16'h1234, 4'd4);
        wait_result("ror4", 16'h4123);
        issue(OP_SRL, 16'h8000, 4'd15);
        wait_result("b2b_srl15", 16'h0001);
        step();
        check_eq("b2b:pulse", 32'(bus_if.Done), 32'd0);

        // Zero count passes the operand through with full latency for every op
        for (int o = 0; o < 4; o++) begin
            run_op("cnt0", 2'(o), 16'hA5A5, 4'd0, 16'hA5A5);
        end

        // Start during SHIFT must not disturb the running request
        issue(OP_ROL, 16'h1234, 4'd4);
        check_eq("mid:busy1", 32'(bus_if.Busy), 32'd1);
        step();
        bus_if.Start = 1'b1;
        bus_if.Op    = OP_SLL;
        bus_if.In    = 16'hFFFF;
        bus_if.Cnt   = 4'd1;
        step();
        bus_if.Start = 1'b0;
        check_eq("mid:busy3", 32'(bus_if.Busy), 32'd1);
        step();
        check_eq("mid:busy4", 32'(bus_if.Busy), 32'd1);
        check_eq("mid:nodone4", 32'(bus_if.Done), 32'd0);
        step();
        check_eq("mid:done", 32'(bus_if.Done), 32'd1);
        check_eq("mid:out", 32'(bus_if.Out), 32'h2341);
        step();
        check_eq("mid:once", 32'(bus_if.Done), 32'd0);
        check_eq("mid:idle", 32'(bus_if.Busy), 32'd0);
        last_out = 16'h2341;

        // Reset in the third SHIFT cycle aborts and clears Out
        issue(OP_SLL, 16'h00FF, 4'd4);
        step();
        step();
        check_eq("abort:busy3", 32'(bus_if.Busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort:busy", 32'(bus_if.Busy), 32'd0);
        check_eq("abort:done", 32'(bus_if.Done), 32'd0);
        check_eq("abort:out", 32'(bus_if.Out), 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            saw_done = saw_done | bus_if.Done;
        end
        check_eq("abort:nodone", 32'(saw_done), 32'd0);
        check_eq("abort:outkept", 32'(bus_if.Out), 32'd0);
        last_out = 16'h0000;

        run_op("after_abort", OP_SRL, 16'hF00F, 4'd4, 16'h0F00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
